// File: rtl/team_06_fx_pkg.sv
// Shared types and constants for the team_06 effects sequencer.
package team_06_fx_pkg;

    localparam int SAMPLE_W_DEF = 8;
    localparam int NUM_FX_DEF   = 4;
    localparam int TIMEOUT_DEF  = 15;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        ISSUE,
        WAIT
    } fx_state_e;

    // Slot index must reach NUM_FX itself (the "all slots done" marker).
    function automatic int slot_idx_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/team_06_fx_watchdog.sv
// Per-slot timeout counter: cleared at each start, counts WAIT cycles.
module team_06_fx_watchdog #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic             clkdiv,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear has priority over load, load over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clkdiv or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/team_06_fx_sequencer.sv
// Hands each captured sample through the enabled effect slots in order.
module team_06_fx_sequencer
    import team_06_fx_pkg::*;
#(
    parameter int NUM_FX   = NUM_FX_DEF,
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                         clkdiv,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [SAMPLE_W-1:0]          sample_in,
    input  logic                         sample_valid,
    input  logic [NUM_FX-1:0]            fx_en_mask,
    output logic [NUM_FX-1:0]            fx_start,
    output logic [SAMPLE_W-1:0]          fx_data_out,
    input  logic [NUM_FX*SAMPLE_W-1:0]   fx_data_in,
    input  logic [NUM_FX-1:0]            fx_done,
    input  logic                         err_clr,
    output logic [SAMPLE_W-1:0]          audio_out,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         overrun,
    output logic                         timeout_err
);

    localparam int SLOT_W = slot_idx_w(NUM_FX);
    localparam int TMR_W  = $clog2(TIMEOUT + 1);
    localparam logic [SLOT_W-1:0] SLOT_END = SLOT_W'(NUM_FX);

    fx_state_e           state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [SAMPLE_W-1:0] acc_q, acc_d;
    logic [NUM_FX-1:0]   mask_q, mask_d;
    logic [SAMPLE_W-1:0] audio_q, audio_d;
    logic                out_valid_q, out_valid_d;
    logic                overrun_q, overrun_d;
    logic                timeout_q, timeout_d;

    logic                cur_en;
    logic                cur_done;
    logic [SAMPLE_W-1:0] cur_data;
    logic [NUM_FX-1:0]   slot_onehot;
    logic                tmr_expired;
    logic                timeout_set;

    // Select the current slot's mask bit, done, result and one-hot code.
    always_comb begin
        cur_en      = 1'b0;
        cur_done    = 1'b0;
        cur_data    = '0;
        slot_onehot = '0;
        for (int k = 0; k < NUM_FX; k++) begin
            if (slot_q == SLOT_W'(k)) begin
                cur_en         = mask_q[k];
                cur_done       = fx_done[k];
                cur_data       = fx_data_in[k*SAMPLE_W +: SAMPLE_W];
                slot_onehot[k] = 1'b1;
            end
        end
    end

    // Timer runs only while waiting on a slot that has not answered yet.
    team_06_fx_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (TMR_W)
    ) u_watchdog (
        .clkdiv   (clkdiv),
        .rst_n    (rst_n),
        .clr      (state_q == ISSUE),
        .load     (1'b0),
        .load_val ('0),
        .en       ((state_q == WAIT) && !cur_done && !tmr_expired),
        .expired  (tmr_expired)
    );

    // FSM next-state, accumulator, snapshot and sticky flag logic.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        acc_d       = acc_q;
        mask_d      = mask_q;
        audio_d     = audio_q;
        out_valid_d = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    acc_d   = sample_in;
                    mask_d  = fx_en_mask & {NUM_FX{en}};
                    slot_d  = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (slot_q == SLOT_END) begin
                    audio_d     = acc_q;
                    out_valid_d = 1'b1;
                    state_d     = IDLE;
                end else if (cur_en) begin
                    state_d = ISSUE;
                end else begin
                    slot_d = slot_q + SLOT_W'(1);
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (cur_done) begin
                    acc_d   = cur_data;
                    slot_d  = slot_q + SLOT_W'(1);
                    state_d = SCAN;
                end else if (tmr_expired) begin
                    timeout_set = 1'b1;
                    slot_d      = slot_q + SLOT_W'(1);
                    state_d     = SCAN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        overrun_d = (sample_valid && (state_q != IDLE)) || (overrun_q && !err_clr);
        timeout_d = timeout_set || (timeout_q && !err_clr);
    end

    // All sequencer state registers.
    always_ff @(posedge clkdiv or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            acc_q       <= '0;
            mask_q      <= '0;
            audio_q     <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            acc_q       <= acc_d;
            mask_q      <= mask_d;
            audio_q     <= audio_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    assign fx_start    = (state_q == ISSUE) ? slot_onehot : '0;
    assign fx_data_out = acc_q;
    assign audio_out   = audio_q;
    assign out_valid   = out_valid_q;
    assign busy        = (state_q != IDLE);
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_team_06_fx_sequencer.sv
// Scoreboard bench for team_06_fx_sequencer with behavioural effect slots.
module tb_team_06_fx_sequencer;

    logic        clkdiv;
    logic        rst_n;
    logic        en;
    logic [7:0]  sample_in;
    logic        sample_valid;
    logic [3:0]  fx_en_mask;
    logic [3:0]  fx_start;
    logic [7:0]  fx_data_out;
    logic [31:0] fx_data_in;
    logic [3:0]  fx_done;
    logic        err_clr;
    logic [7:0]  audio_out;
    logic        out_valid;
    logic        busy;
    logic        overrun;
    logic        timeout_err;

    typedef struct {
        logic [7:0] audio;
        int         lat;
        int         cap;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   start_log[$];
    int   dly[4];
    int   op[4];
    int   cyc = 0;
    int   compared = 0;
    int   failed = 0;
    int   onehot_bad = 0;

    localparam int OP_SHR = 0;
    localparam int OP_INC = 1;
    localparam int OP_XOR = 2;

    team_06_fx_sequencer dut (
        .clkdiv       (clkdiv),
        .rst_n        (rst_n),
        .en           (en),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .fx_en_mask   (fx_en_mask),
        .fx_start     (fx_start),
        .fx_data_out  (fx_data_out),
        .fx_data_in   (fx_data_in),
        .fx_done      (fx_done),
        .err_clr      (err_clr),
        .audio_out    (audio_out),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    // Free-running clock.
    initial clkdiv = 1'b0;
    always #5 clkdiv = ~clkdiv;

    // Cycle counter used to time capture-to-output latency.
    always @(posedge clkdiv) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] s, input logic [7:0] exp_audio,
                                  input int lat, input bit expect_out);
        exp_t e;
        @(negedge clkdiv);
        sample_in    = s;
        sample_valid = 1'b1;
        if (expect_out) begin
            e.audio = exp_audio;
            e.lat   = lat;
            e.cap   = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clkdiv);
        sample_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clkdiv);
            n++;
        end
        if (sb.size() != 0) begin
            compared++;
            failed++;
            $display("[TB] FAIL drain_timeout: got %0d pending outputs, required 0", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clkdiv);
    endtask

    task automatic pulse_err_clr();
        @(negedge clkdiv);
        err_clr = 1'b1;
        @(negedge clkdiv);
        err_clr = 1'b0;
    endtask

    // Monitor: pop the expected result whenever the DUT emits a sample.
    always @(negedge clkdiv) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                compared++;
                failed++;
                $display("[TB] FAIL unexpected_out: got audio_out=%0h, required no output", audio_out);
            end else begin
                mon_e = sb.pop_front();
                check_output("audio_out", {24'd0, audio_out}, {24'd0, mon_e.audio});
                check_output("latency", cyc - mon_e.cap, mon_e.lat);
            end
        end
    end

    // Start pulses must never select more than one slot.
    always @(negedge clkdiv) begin
        if (!$onehot0(fx_start)) onehot_bad++;
    end

    // Behavioural effect slots answering the shared start/done handshake.
    initial begin
        int         k;
        logic [7:0] x;
        logic [7:0] r;
        fx_done    = '0;
        fx_data_in = '0;
        forever begin
            @(negedge clkdiv);
            if (rst_n && fx_start != '0) begin
                k = 0;
                for (int i = 0; i < 4; i++) if (fx_start[i]) k = i;
                start_log.push_back(k);
                x = fx_data_out;
                case (op[k])
                    OP_SHR:  r = x >> 1;
                    OP_INC:  r = x + 8'd1;
                    default: r = x ^ 8'h0F;
                endcase
                if (dly[k] > 0) begin
                    repeat (dly[k]) @(negedge clkdiv);
                    fx_data_in[k*8 +: 8] = r;
                    fx_done[k]           = 1'b1;
                    @(negedge clkdiv);
                    fx_done = '0;
                end
            end
        end
    end

    // Overall time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, required finish");
        $fatal(1, "[TB] global timeout");
    end

    // Directed test sequence.
    initial begin
        bit found;
        rst_n        = 1'b0;
        en           = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        fx_en_mask   = '0;
        err_clr      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dly[i] = 0;
            op[i]  = OP_SHR;
        end
        repeat (3) @(negedge clkdiv);
        rst_n = 1'b1;
        @(negedge clkdiv);
        check_output("rst_audio_out", {24'd0, audio_out}, 32'd0);
        check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        check_output("rst_overrun", {31'd0, overrun}, 32'd0);
        check_output("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        check_output("rst_fx_start", {28'd0, fx_start}, 32'd0);
        check_output("rst_fx_data_out", {24'd0, fx_data_out}, 32'd0);

        $display("[TB] bypass");
        start_log.delete();
        fx_en_mask = 4'b0000;
        apply_stimulus(8'hE5, 8'hE5, 5, 1'b1);
        check_output("bypass_busy", {31'd0, busy}, 32'd1);
        wait_drain(40);
        check_output("bypass_starts", start_log.size(), 32'd0);

        $display("[TB] single slot");
        start_log.delete();
        fx_en_mask = 4'b0001;
        dly[0] = 3; op[0] = OP_SHR;
        apply_stimulus(8'hFF, 8'h7F, 9, 1'b1);
        wait_drain(40);
        check_output("single_starts", start_log.size(), 32'd1);
        if (start_log.size() > 0) check_output("single_slot", start_log[0], 32'd0);

        $display("[TB] chain");
        start_log.delete();
        fx_en_mask = 4'b1010;
        dly[1] = 1; op[1] = OP_INC;
        dly[3] = 2; op[3] = OP_XOR;
        apply_stimulus(8'h04, 8'h0A, 10, 1'b1);
        wait_drain(40);
        check_output("chain_starts", start_log.size(), 32'd2);
        if (start_log.size() > 1) begin
            check_output("chain_first", start_log[0], 32'd1);
            check_output("chain_second", start_log[1], 32'd3);
        end

        $display("[TB] timeout");
        fx_en_mask = 4'b0100;
        dly[2] = 0;
        apply_stimulus(8'h80, 8'h80, 21, 1'b1);
        check_output("timeout_pending", {31'd0, timeout_err}, 32'd0);
        wait_drain(60);
        check_output("timeout_set", {31'd0, timeout_err}, 32'd1);
        pulse_err_clr();
        check_output("timeout_cleared", {31'd0, timeout_err}, 32'd0);

        $display("[TB] overrun");
        fx_en_mask = 4'b0001;
        dly[0] = 3; op[0] = OP_SHR;
        apply_stimulus(8'h40, 8'h20, 9, 1'b1);
        apply_stimulus(8'h11, 8'h00, 0, 1'b0);
        check_output("overrun_set", {31'd0, overrun}, 32'd1);
        check_output("overrun_busy", {31'd0, busy}, 32'd1);
        wait_drain(40);
        pulse_err_clr();
        check_output("overrun_cleared", {31'd0, overrun}, 32'd0);

        $display("[TB] back-to-back");
        fx_en_mask = 4'b0000;
        apply_stimulus(8'hA1, 8'hA1, 5, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clkdiv);
            if (out_valid) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            compared++;
            failed++;
            $display("[TB] FAIL b2b_out_valid: got no out_valid, required one");
        end else begin
            sample_in    = 8'hB2;
            sample_valid = 1'b1;
            sb.push_back('{audio: 8'hB2, lat: 5, cap: cyc + 1});
            @(negedge clkdiv);
            sample_valid = 1'b0;
        end
        wait_drain(40);
        check_output("b2b_overrun", {31'd0, overrun}, 32'd0);

        $display("[TB] en low");
        start_log.delete();
        en         = 1'b0;
        fx_en_mask = 4'b1111;
        apply_stimulus(8'h3C, 8'h3C, 5, 1'b1);
        wait_drain(80);
        check_output("en_low_starts", start_log.size(), 32'd0);
        en = 1'b1;

        $display("[TB] reset mid-wait");
        fx_en_mask = 4'b0100;
        dly[2] = 0;
        apply_stimulus(8'h55, 8'h00, 0, 1'b0);
        repeat (5) @(negedge clkdiv);
        check_output("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_output("mid_rst_audio_out", {24'd0, audio_out}, 32'd0);
        check_output("mid_rst_fx_start", {28'd0, fx_start}, 32'd0);
        check_output("mid_rst_fx_data_out", {24'd0, fx_data_out}, 32'd0);
        check_output("mid_rst_timeout_err", {31'd0, timeout_err}, 32'd0);
        @(negedge clkdiv);
        rst_n = 1'b1;
        @(negedge clkdiv);
        fx_en_mask = 4'b0001;
        dly[0] = 1; op[0] = OP_INC;
        apply_stimulus(8'h10, 8'h11, 7, 1'b1);
        wait_drain(40);

        check_output("fx_start_onehot", onehot_bad, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
